serial_cmp_lsb: RTL and testbench
=================================

// Module: serial_cmp_lsb
// PURPOSE
//  Bit-serial magnitude comparator consuming operand streams LSB-first, one bit pair per accepted beat.
//  It is the LSB-first counterpart of the team's MSB-first shift-register comparator.
//  It sits at the receive end of the serial datapath, where operands arrive low bit first.
//  Supports unsigned and two's-complement compare; result is held until the next operation.
// PARAMETERS
//  WIDTH   32   operand width in bits (>=1); number of beats per compare
//  CNT_W   $clog2(WIDTH+1)   bit-counter width (derived, not overridden)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-low reset
//  start        in   1        begin a new compare (accepted only in IDLE or DONE)
//  signed_mode  in   1        sampled with start: 1 = two's-complement, 0 = unsigned
//  bit_valid    in   1        a_bit/b_bit carry a valid bit pair this cycle
//  a_bit        in   1        serial bit of operand A, LSB first
//  b_bit        in   1        serial bit of operand B, LSB first
//  bit_ready    out  1        block accepts a bit pair this cycle (high only in RUN)
//  busy         out  1        compare in progress (RUN)
//  done         out  1        one-cycle pulse the cycle after the final bit is accepted
//  L            out  1        A < B (valid in DONE, held)
//  E            out  1        A == B (valid in DONE, held)
//  G            out  1        A > B (valid in DONE, held)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, count=0, rel=EQ, sgn=0, bit_ready=0, busy=0, done=0, L=0, E=1, G=0.
//  - FSM states: IDLE, RUN, DONE; encoded 2 bits.
//  - Transitions:
//    IDLE -> RUN on start;
//    RUN -> DONE when the beat with count==WIDTH-1 is accepted;
//    DONE -> RUN on start;
//    DONE holds otherwise.
//  - On the start edge: count<=0, rel<=EQ, sgn<=signed_mode.
//  - start is ignored while in RUN; there is no abort.
//  - Beat accepted = RUN & bit_valid (bit_ready==1 in RUN); bit_valid low stalls, state unchanged.
//  - Per accepted beat, the newer (more significant) bit dominates:
//    - a_bit==b_bit: rel unchanged;
//    - a=1,b=0: rel<=GT;
//    - a=0,b=1: rel<=LT.
//  - Signed final beat (count==WIDTH-1, sgn=1) with differing bits: inverted, a=1,b=0 -> LT and a=0,b=1 -> GT.
//  - rel encoding 2 bits: EQ=00, GT=01, LT=10 (11 unreachable; decode as EQ).
//  - count increments by 1 per accepted beat, never exceeds WIDTH-1, does not wrap; reset to 0 on start.
//  - L/E/G are registered and update together on the final-beat edge, exactly one-hot.
//  - done asserts the cycle after that edge, for exactly 1 cycle, while state=DONE.
//  - Latency: start cycle + WIDTH accepted beats; done one cycle after the last beat (min WIDTH+1 cycles after start).
//  - L/E/G keep their last result through IDLE/RUN of a following compare until its final beat.
//  - Outputs are never X after reset.
//  - start and the final beat never coincide (start ignored in RUN).
//  - start in DONE on the same cycle as bit_valid: start wins and that bit is not consumed (bit_ready=0 in DONE).
//  - Reset mid-RUN: returns to IDLE, partial compare discarded, outputs take reset values.
//  - WIDTH=1: single beat; in signed mode it is the sign bit only (A=1,B=0 -> L).
// TESTING
//  1. Unsigned, WIDTH=32: A=0x0000_0005, B=0x0000_0003, bit_valid always 1 -> done at cycle 33 after start, G=1, L=0, E=0.
//  2. Unsigned: A=0x8000_0000, B=0x7FFF_FFFF -> G=1; then signed with the same operands -> L=1 (MSB inversion).
//  3. Equal operands A=B=0xDEAD_BEEF, with bit_valid deasserted for 3 random cycles -> E=1, done delayed by exactly 3 cycles, count never exceeds 31.
//  4. Early vs late difference: A=0x0000_0001, B=0x0000_0100 unsigned -> L=1 (later bit overrides earlier GT). Signed A=-1 (0xFFFF_FFFF), B=0 -> L=1.
//  5. Reset low at beat 10 of a compare -> next cycle IDLE, E=1, busy=0, done=0. A fresh compare of A=2, B=2 -> E=1.
//  6. Protocol: start pulses during RUN are ignored (result unchanged). Back-to-back start in the DONE cycle with A=1, B=0 -> second result G=1, done pulses once per compare.

Source files
------------

// File: rtl/serial_cmp_lsb.sv
// Bit-serial magnitude comparator, operands arrive LSB first; unsigned or two's-complement.
// The most recent differing bit decides the relation, so the final (sign) beat has the last word.
module serial_cmp_lsb #(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic signed_mode,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic bit_ready,
   output logic busy,
   output logic done,
   output logic L,
   output logic E,
   output logic G
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REL_EQ = 2'b00,
      REL_GT = 2'b01,
      REL_LT = 2'b10
   } rel_t;

   state_t           state, state_nxt;
   rel_t             rel, rel_nxt;
   logic [CNT_W-1:0] count;
   logic             sgn;
   logic             beat, last, take_start;
   logic [2:0]       leg_nxt;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      bit_ready  = 1'b0;
      busy       = 1'b0;
      beat       = (state == RUN) && bit_valid;
      last       = beat && (count == CNT_W'(WIDTH - 1));
      take_start = start && (state != RUN);
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            bit_ready = 1'b1;
            busy      = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Differing bits overwrite the relation; on the signed sign beat the sense flips.
   always_comb begin
      rel_nxt = rel;
      if (a_bit != b_bit) begin
         if (last && sgn) begin
            if (a_bit) rel_nxt = REL_LT;
            else       rel_nxt = REL_GT;
         end else begin
            if (a_bit) rel_nxt = REL_GT;
            else       rel_nxt = REL_LT;
         end
      end
      case (rel_nxt)
         REL_GT:  leg_nxt = 3'b001;
         REL_LT:  leg_nxt = 3'b100;
         default: leg_nxt = 3'b010;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
         rel   <= REL_EQ;
         sgn   <= 1'b0;
         done  <= 1'b0;
         L     <= 1'b0;
         E     <= 1'b1;
         G     <= 1'b0;
      end else begin
         done <= last;
         if (take_start) begin
            count <= '0;
            rel   <= REL_EQ;
            sgn   <= signed_mode;
         end else if (beat) begin
            rel <= rel_nxt;
            if (last) {L, E, G} <= leg_nxt;
            else      count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_cmp_lsb.sv
// Directed bench for serial_cmp_lsb: table of 32-bit compares plus reset, stall,
// back-to-back and single-bit corner sequences.
module tb_serial_cmp_lsb;

   logic clk = 1'b0;
   logic reset, start, signed_mode, bit_valid, a_bit, b_bit;
   logic bit_ready, busy, done, L, E, G;

   logic s1_start, s1_sm, s1_valid, s1_a, s1_b;
   logic s1_ready, s1_busy, s1_done, s1_L, s1_E, s1_G;

   int checks   = 0;
   int failures = 0;
   logic ovf    = 1'b0;

   always #5 clk = ~clk;

   serial_cmp_lsb #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
      .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
      .bit_ready(bit_ready), .busy(busy), .done(done), .L(L), .E(E), .G(G)
   );

   serial_cmp_lsb #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(s1_start), .signed_mode(s1_sm),
      .bit_valid(s1_valid), .a_bit(s1_a), .b_bit(s1_b),
      .bit_ready(s1_ready), .busy(s1_busy), .done(s1_done), .L(s1_L), .E(s1_E), .G(s1_G)
   );

   always @(negedge clk) if (reset && dut.count > 6'd31) ovf = 1'b1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sm;
      int          stall_at;
      int          nstall;
      int          glitch_at;
      logic [2:0]  exp_leg;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts at a negedge, returns at the negedge where done is first seen (or the bound expires).
   task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input int stall_at, input int nstall, input int glitch_at,
                         input logic junk, output int lat, output logic [2:0] leg,
                         output logic run_ok);
      start = 1'b1; signed_mode = sm; bit_valid = junk; a_bit = 1'b0; b_bit = junk;
      @(negedge clk);
      start = 1'b0; signed_mode = ~sm; lat = 1; run_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i == stall_at)
            for (int s = 0; s < nstall; s++) begin
               bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
               @(negedge clk); lat++;
               if (done !== 1'b0 || busy !== 1'b1) run_ok = 1'b0;
            end
         bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i]; start = (i == glitch_at);
         if (bit_ready !== 1'b1) run_ok = 1'b0;
         @(negedge clk); lat++; start = 1'b0;
         if (i < 31 && (done !== 1'b0 || busy !== 1'b1)) run_ok = 1'b0;
      end
      bit_valid = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk); lat++;
      end
      leg = {L, E, G};
   endtask

   initial begin
      int         lat;
      logic [2:0] leg;
      logic       ok;

      tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, -1, 0, -1, 3'b001};
      tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, -1, 0, 12, 3'b001};
      tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, -1, 0, -1, 3'b100};
      tbl[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0,  7, 3, -1, 3'b010};
      tbl[4] = '{32'h0000_0001, 32'h0000_0100, 1'b0, -1, 0, -1, 3'b100};
      tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, -1, 0, -1, 3'b100};
      tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, -1, 0, 20, 3'b001};
      tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, -1, 0, -1, 3'b001};
      tbl[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 30, 2, -1, 3'b100};
      tbl[9] = '{32'h0000_0002, 32'h0000_0002, 1'b0, -1, 0, -1, 3'b010};

      reset = 1'b0; start = 1'b0; signed_mode = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      s1_start = 1'b0; s1_sm = 1'b0; s1_valid = 1'b0; s1_a = 1'b0; s1_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {26'd0, bit_ready, busy, done, L, E, G}, 32'b000010);
      reset = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         do_cmp(tbl[v].a, tbl[v].b, tbl[v].sm, tbl[v].stall_at, tbl[v].nstall,
                tbl[v].glitch_at, 1'b0, lat, leg, ok);
         check($sformatf("vec%0d_latency", v), 32'(lat), 32'(33 + tbl[v].nstall));
         check($sformatf("vec%0d_LEG", v), {29'd0, leg}, {29'd0, tbl[v].exp_leg});
         check($sformatf("vec%0d_run_protocol", v), {31'd0, ok}, 32'd1);
         @(negedge clk);
         check($sformatf("vec%0d_done_one_cycle", v), {31'd0, done}, 32'd0);
         check($sformatf("vec%0d_LEG_held", v), {29'd0, L, E, G}, {29'd0, tbl[v].exp_leg});
      end

      // Back-to-back: second start lands in the done cycle alongside a junk bit.
      do_cmp(32'h0, 32'h1, 1'b0, -1, 0, -1, 1'b0, lat, leg, ok);
      check("b2b_first_LEG", {29'd0, leg}, 32'b100);
      do_cmp(32'h1, 32'h0, 1'b0, -1, 0, -1, 1'b1, lat, leg, ok);
      check("b2b_second_latency", 32'(lat), 32'd33);
      check("b2b_second_LEG", {29'd0, leg}, 32'b001);
      check("b2b_second_protocol", {31'd0, ok}, 32'd1);

      // Reset at beat 10 of a compare.
      start = 1'b1; signed_mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bit_valid = 1'b1; a_bit = (i == 0); b_bit = (i == 1);
         @(negedge clk);
      end
      check("mid_run_busy_before_reset", {31'd0, busy}, 32'd1);
      reset = 1'b0; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      @(negedge clk);
      check("mid_run_reset_outputs", {26'd0, bit_ready, busy, done, L, E, G}, 32'b000010);
      reset = 1'b1; bit_valid = 1'b0;
      @(negedge clk);
      check("after_reset_idle_busy", {31'd0, busy}, 32'd0);
      do_cmp(32'h2, 32'h2, 1'b0, -1, 0, -1, 1'b0, lat, leg, ok);
      check("post_reset_latency", 32'(lat), 32'd33);
      check("post_reset_LEG", {29'd0, leg}, 32'b010);
      check("count_in_range", {31'd0, ovf}, 32'd0);

      // WIDTH=1: the only bit is the sign bit in signed mode.
      for (int m = 0; m < 2; m++) begin
         s1_start = 1'b1; s1_sm = (m == 0);
         @(negedge clk);
         s1_start = 1'b0; s1_sm = 1'b0; s1_valid = 1'b1; s1_a = 1'b1; s1_b = 1'b0;
         check($sformatf("w1_m%0d_ready", m), {31'd0, s1_ready}, 32'd1);
         @(negedge clk);
         s1_valid = 1'b0;
         check($sformatf("w1_m%0d_done", m), {31'd0, s1_done}, 32'd1);
         check($sformatf("w1_m%0d_LEG", m), {29'd0, s1_L, s1_E, s1_G},
               (m == 0) ? 32'b100 : 32'b001);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
